// File: rtl/bram_stream_loader.sv
// bram_stream_loader
// Streams packed {hi16, lo16} words from a valid/ready source into three BRAM
// banks through their port B: node (b0), then weight (b1), then bias (b2).
// Each bank receives n = min(i_num_cnt, MEM_SIZE) words at addresses 0..n-1.
// o_done pulses for one cycle once all three banks hold a complete frame.
//
// Handshake: a word transfers on a rising edge where s_valid & s_ready are
// both 1; s_ready is high exactly while the FSM is in LOAD, the source may
// drop s_valid on any cycle, and only transferred words produce BRAM writes.
module bram_stream_loader #(
   parameter int CNT_BIT  = 31,
   parameter int DWIDTH   = 32,
   parameter int AWIDTH   = 12,
   parameter int MEM_SIZE = 4096
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               i_run,
   input  logic [CNT_BIT-1:0] i_num_cnt,
   output logic               o_idle,
   output logic               o_load,
   output logic               o_done,
   output logic [1:0]         o_state,
   input  logic               s_valid,
   output logic               s_ready,
   input  logic [DWIDTH-1:0]  s_data,
   output logic [AWIDTH-1:0]  addr_b0,
   output logic               ce_b0,
   output logic               we_b0,
   output logic [DWIDTH-1:0]  d_b0,
   output logic [AWIDTH-1:0]  addr_b1,
   output logic               ce_b1,
   output logic               we_b1,
   output logic [DWIDTH-1:0]  d_b1,
   output logic [AWIDTH-1:0]  addr_b2,
   output logic               ce_b2,
   output logic               we_b2,
   output logic [DWIDTH-1:0]  d_b2
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LOAD = 2'd1,
      S_DONE = 2'd2
   } state_t;

   localparam logic [CNT_BIT-1:0] MEM_SIZE_C = CNT_BIT'(MEM_SIZE);

   state_t             state_q;
   logic [CNT_BIT-1:0] n_q;
   logic [CNT_BIT-1:0] n_d;
   logic [CNT_BIT-1:0] cnt_q;
   logic [CNT_BIT-1:0] cnt_d;
   logic [1:0]         bank_q;
   logic [1:0]         bank_d;
   logic               idle_q;
   logic               load_q;
   logic               done_q;
   logic               hs;
   logic               last_word;

   logic [2:0]         ce_q;
   logic [AWIDTH-1:0]  addr_q [3];
   logic [DWIDTH-1:0]  data_q [3];

   // Clamped frame length, handshake detection and word/bank advance
   always_comb begin
      n_d       = (i_num_cnt > MEM_SIZE_C) ? MEM_SIZE_C : i_num_cnt;
      hs        = s_valid & s_ready;
      last_word = (cnt_q == (n_q - CNT_BIT'(1)));
      cnt_d     = cnt_q;
      bank_d    = bank_q;
      if (hs) begin
         if (last_word) begin
            cnt_d  = '0;
            bank_d = bank_q + 2'd1;
         end else begin
            cnt_d  = cnt_q + CNT_BIT'(1);
         end
      end
   end

   // Control FSM: state, frame length, word counter, bank select, status flags
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         n_q     <= '0;
         cnt_q   <= '0;
         bank_q  <= 2'd0;
         idle_q  <= 1'b1;
         load_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (i_run) begin
                  n_q    <= n_d;
                  cnt_q  <= '0;
                  bank_q <= 2'd0;
                  idle_q <= 1'b0;
                  if (n_d == '0) begin
                     state_q <= S_DONE;
                     done_q  <= 1'b1;
                  end else begin
                     state_q <= S_LOAD;
                     load_q  <= 1'b1;
                  end
               end
            end
            S_LOAD: begin
               cnt_q  <= cnt_d;
               bank_q <= bank_d;
               // The final word of bank 2 closes the frame; its write lands during DONE
               if (hs && last_word && (bank_q == 2'd2)) begin
                  state_q <= S_DONE;
                  load_q  <= 1'b0;
                  done_q  <= 1'b1;
               end
            end
            S_DONE: begin
               state_q <= S_IDLE;
               done_q  <= 1'b0;
               idle_q  <= 1'b1;
            end
            default: begin
               state_q <= S_IDLE;
               load_q  <= 1'b0;
               done_q  <= 1'b0;
               idle_q  <= 1'b1;
            end
         endcase
      end
   end

   // Registered BRAM write port: one-cycle pulse on the selected bank, addr/data hold otherwise
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ce_q <= 3'b000;
         for (int k = 0; k < 3; k++) begin
            addr_q[k] <= '0;
            data_q[k] <= '0;
         end
      end else begin
         for (int k = 0; k < 3; k++) begin
            if (hs && (bank_q == 2'(k))) begin
               ce_q[k]   <= 1'b1;
               addr_q[k] <= cnt_q[AWIDTH-1:0];
               data_q[k] <= s_data;
            end else begin
               ce_q[k]   <= 1'b0;
            end
         end
      end
   end

   assign s_ready = (state_q == S_LOAD);
   assign o_idle  = idle_q;
   assign o_load  = load_q;
   assign o_done  = done_q;
   assign o_state = state_q;

   assign ce_b0   = ce_q[0];
   assign we_b0   = ce_q[0];
   assign addr_b0 = addr_q[0];
   assign d_b0    = data_q[0];
   assign ce_b1   = ce_q[1];
   assign we_b1   = ce_q[1];
   assign addr_b1 = addr_q[1];
   assign d_b1    = data_q[1];
   assign ce_b2   = ce_q[2];
   assign we_b2   = ce_q[2];
   assign addr_b2 = addr_q[2];
   assign d_b2    = data_q[2];

endmodule
